// File: rtl/fmult_core.sv
// G.726 FMULT: 16-bit fixed-point coefficient times 11-bit float signal, registered result.
// Optional input register stage (2-cycle latency) enabled by defining FMULT_PIPE_EN.
module fmult_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] an,
    input  logic [10:0] srn,
    output logic        out_valid,
    output logic [15:0] wan,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);

    localparam int unsigned AN_W    = 16;
    localparam int unsigned SRN_W   = 11;
    localparam int unsigned MAG_W   = 13;
    localparam int unsigned EXP_W   = 4;
    localparam int unsigned MANT_W  = 6;
    localparam int unsigned WEXP_W  = 5;
    localparam int unsigned PROD_W  = 12;
    localparam int unsigned WMANT_W = 8;
    localparam int unsigned WMAG_W  = 15;
    localparam int unsigned SHF_W   = 17;

    logic              s_valid;
    logic [AN_W-1:0]   s_an;
    logic [SRN_W-1:0]  s_srn;

`ifdef FMULT_PIPE_EN
    // Input register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid <= 1'b0;
            s_an    <= '0;
            s_srn   <= '0;
        end else begin
            s_valid <= in_valid;
            s_an    <= an;
            s_srn   <= srn;
        end
    end
`else
    assign s_valid = in_valid;
    assign s_an    = an;
    assign s_srn   = srn;
`endif

    logic [AN_W-1:0]    an_neg_c;
    logic [MAG_W-1:0]   an_mag_c;
    logic [EXP_W-1:0]   an_exp_c;
    logic [MANT_W-1:0]  an_mant_c;
    logic [MAG_W+MANT_W-1:0] an_norm_c;
    logic               wan_s_c;
    logic [WEXP_W-1:0]  wan_exp_c;
    logic [PROD_W-1:0]  prod_c;
    logic [WMANT_W-1:0] wan_mant_c;
    logic [SHF_W-1:0]   base_c;
    logic [SHF_W-1:0]   shifted_c;
    logic [WMAG_W-1:0]  wan_mag_c;
    logic [AN_W-1:0]    wan_mag_ext_c;
    logic [AN_W-1:0]    wan_c;

    // Coefficient magnitude; -0x8000 falls out of the 13-bit field as zero
    assign an_neg_c = ~s_an + 16'd1;
    assign an_mag_c = s_an[15] ? an_neg_c[14:2] : s_an[14:2];

    // Exponent is MSB index + 1 (0 for a zero magnitude)
    always_comb begin
        an_exp_c = '0;
        for (int i = 0; i < int'(MAG_W); i++) begin
            if (an_mag_c[i]) an_exp_c = EXP_W'(i + 1);
        end
    end

    assign an_norm_c = {an_mag_c, 6'b000000} >> an_exp_c;
    assign an_mant_c = (an_mag_c == '0) ? 6'd32 : an_norm_c[MANT_W-1:0];

    assign wan_s_c    = s_srn[10] ^ s_an[15];
    assign wan_exp_c  = WEXP_W'(s_srn[9:6]) + WEXP_W'(an_exp_c);
    assign prod_c     = PROD_W'(s_srn[5:0]) * PROD_W'(an_mant_c) + 12'd48;
    assign wan_mant_c = prod_c[PROD_W-1:4];

    // Denormalize around exponent 26; left shifts overflow into masked-off bits
    assign base_c    = SHF_W'({wan_mant_c, 7'b0000000});
    assign shifted_c = (wan_exp_c <= 5'd26) ? (base_c >> (5'd26 - wan_exp_c))
                                            : (base_c << (wan_exp_c - 5'd26));
    assign wan_mag_c = shifted_c[WMAG_W-1:0];

    assign wan_mag_ext_c = {1'b0, wan_mag_c};
    assign wan_c         = wan_s_c ? (~wan_mag_ext_c + 16'd1) : wan_mag_ext_c;

    // Output register; wan holds while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            wan       <= '0;
        end else begin
            out_valid <= s_valid;
            if (s_valid) wan <= wan_c;
        end
    end

    // Scan chains are stitched at synthesis
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    logic unused_sink;
    assign unused_sink = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode, an_neg_c[15], an_neg_c[1:0],
                           s_an[1:0], prod_c[3:0], shifted_c[SHF_W-1:WMAG_W]};

endmodule

// File: tb/tb_fmult_core.sv
// Directed self-checking bench for fmult_core; latency follows FMULT_PIPE_EN.
module tb_fmult_core;

`ifdef FMULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] an;
    logic [10:0] srn;
    logic        out_valid;
    logic [15:0] wan;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable, test_mode;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int n_assert = 0;
    int n_fail   = 0;

    fmult_core dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .an         (an),
        .srn        (srn),
        .out_valid  (out_valid),
        .wan        (wan),
        .scan_in0   (scan_in0),
        .scan_in1   (scan_in1),
        .scan_in2   (scan_in2),
        .scan_in3   (scan_in3),
        .scan_in4   (scan_in4),
        .scan_enable(scan_enable),
        .test_mode  (test_mode),
        .scan_out0  (scan_out0),
        .scan_out1  (scan_out1),
        .scan_out2  (scan_out2),
        .scan_out3  (scan_out3),
        .scan_out4  (scan_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // One isolated operation: check result after LAT edges, then idle deassert and hold
    task automatic run_op(input string tag, input logic [15:0] a, input logic [10:0] s,
                          input logic [15:0] exp);
        an = a;
        srn = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < LAT; k++) step();
        check({tag, "_valid"}, 16'(out_valid), 16'h0001);
        check({tag, "_wan"}, wan, exp);
        step();
        check({tag, "_idle_valid"}, 16'(out_valid), 16'h0000);
        check({tag, "_hold_wan"}, wan, exp);
    endtask

    logic [15:0] st_an  [4];
    logic [10:0] st_srn [4];
    logic [15:0] st_exp [4];

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        an = 16'h0000;
        srn = 11'h000;
        {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b10101;
        scan_enable = 1'b0;
        test_mode = 1'b0;

        step();
        step();
        reset = 1'b0;
        step();
        check("reset_valid", 16'(out_valid), 16'h0000);
        check("reset_wan", wan, 16'h0000);
        check("scan_outs", 16'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 16'h0000);

        run_op("basic",       16'h4000, 11'h160, 16'h0021);
        run_op("neg_an",      16'hC000, 11'h160, 16'hFFDF);
        run_op("neg_srn",     16'h4000, 11'h560, 16'hFFDF);
        run_op("neg_both",    16'hC000, 11'h560, 16'h0021);
        run_op("zero",        16'h0000, 11'h020, 16'h0000);
        run_op("an_min",      16'h8000, 11'h160, 16'h0000);
        run_op("exp28",       16'h7FFF, 11'h3FF, 16'h7600);
        run_op("exp27",       16'h7FFF, 11'h3BF, 16'h7B00);
        run_op("exp26",       16'h7FFF, 11'h37F, 16'h7D80);
        run_op("exp28_neg",   16'h8001, 11'h3FF, 16'h8A00);
        run_op("unnorm_mant", 16'h4000, 11'h140, 16'h0001);
        run_op("generic",     16'h1234, 11'h2A5, 16'h0158);

        scan_enable = 1'b1;
        test_mode = 1'b1;
        run_op("test_mode", 16'h4000, 11'h160, 16'h0021);
        check("scan_outs_tm", 16'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 16'h0000);
        scan_enable = 1'b0;
        test_mode = 1'b0;

        // Back-to-back stream; reset lands where the third result would emerge
        st_an[0] = 16'h4000; st_srn[0] = 11'h160; st_exp[0] = 16'h0021;
        st_an[1] = 16'hC000; st_srn[1] = 11'h160; st_exp[1] = 16'hFFDF;
        st_an[2] = 16'h7FFF; st_srn[2] = 11'h3FF; st_exp[2] = 16'h7600;
        st_an[3] = 16'h4000; st_srn[3] = 11'h560; st_exp[3] = 16'hFFDF;
        for (int k = 1; k <= LAT + 4; k++) begin
            if (k <= 4) begin
                an = st_an[k-1];
                srn = st_srn[k-1];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            reset = (k == LAT + 2) || (k == LAT + 3);
            step();
            if (k < LAT) begin
                check($sformatf("stream_k%0d_valid", k), 16'(out_valid), 16'h0000);
            end else if (k == LAT) begin
                check($sformatf("stream_k%0d_valid", k), 16'(out_valid), 16'h0001);
                check($sformatf("stream_k%0d_wan", k), wan, st_exp[0]);
            end else if (k == LAT + 1) begin
                check($sformatf("stream_k%0d_valid", k), 16'(out_valid), 16'h0001);
                check($sformatf("stream_k%0d_wan", k), wan, st_exp[1]);
            end else begin
                check($sformatf("stream_k%0d_valid", k), 16'(out_valid), 16'h0000);
                check($sformatf("stream_k%0d_wan", k), wan, 16'h0000);
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;

        run_op("post_reset", 16'h4000, 11'h160, 16'h0021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
